// File: rtl/ttrigger_pkg.sv
// Shared constants for the ttrigger T flip-flop bank.
package ttrigger_pkg;

    localparam logic MODE_TOGGLE  = 1'b0;
    localparam logic MODE_COUNTER = 1'b1;

endpackage

// File: rtl/ttrigger_cell.sv
// One T flip-flop bit: async reset value, then clr > set > load > toggle on each rising T.
module ttrigger_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic T,
    input  logic rst_n,
    input  logic clr,
    input  logic set,
    input  logic ld,
    input  logic d,
    input  logic tgl,
    output logic Q,
    output logic nQ
);

    logic q_reg;

    always_ff @(posedge T or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= RESET_VAL;
        end else if (clr) begin
            q_reg <= 1'b0;
        end else if (set) begin
            q_reg <= 1'b1;
        end else if (ld) begin
            q_reg <= d;
        end else if (tgl) begin
            q_reg <= ~q_reg;
        end
    end

    assign Q  = q_reg;
    assign nQ = ~q_reg;

endmodule

// File: rtl/ttrigger.sv
// Bank of WIDTH T flip-flops: independent toggles, or a synchronous up-counter with rollover pulse.
module ttrigger
    import ttrigger_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             T,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] tog,
    input  logic             sclr,
    input  logic             sset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic             wrap
);

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] tgl_bit;
    logic             wrap_reg;
    logic             wrap_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            // In counter mode a bit may only flip once every lower bit is 1.
            if (gi == 0) begin : g_lsb
                assign carry[gi] = 1'b1;
            end else begin : g_upper
                assign carry[gi] = &Q[gi-1:0];
            end

            assign tgl_bit[gi] = en & tog[gi] & ((mode == MODE_TOGGLE) | carry[gi]);

            ttrigger_cell #(
                .RESET_VAL (RESET_VAL[gi])
            ) u_cell (
                .T     (T),
                .rst_n (rst_n),
                .clr   (sclr),
                .set   (sset),
                .ld    (load),
                .d     (d[gi]),
                .tgl   (tgl_bit[gi]),
                .Q     (Q[gi]),
                .nQ    (nQ[gi])
            );
        end
    endgenerate

    // Rollover: all ones moving to all zeros through counting alone.
    assign wrap_next = en & (mode == MODE_COUNTER) & ~(sclr | sset | load)
                     & (&Q) & ~(|(Q ^ tgl_bit));

    always_ff @(posedge T or negedge rst_n) begin
        if (!rst_n) begin
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= wrap_next;
        end
    end

    assign wrap = wrap_reg;

endmodule

// File: tb/tb_ttrigger.sv
// Directed bench for ttrigger: a 1-bit classic TFF and a 4-bit bank share clock and reset.
module tb_ttrigger;

    logic       T;
    logic       rst_n;
    logic       en4, mode4, sclr4, sset4, load4;
    logic [3:0] tog4, d4, q4, nq4;
    logic       wrap4;
    logic       q1, nq1, wrap1;

    int n_pass  = 0;
    int n_check = 0;

    typedef struct {
        logic [3:0] q;
        logic       w;
        logic       q1;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp4;
    logic       exp1;

    ttrigger #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .T(T), .rst_n(rst_n), .en(1'b1), .mode(1'b0), .tog(1'b1),
        .sclr(1'b0), .sset(1'b0), .load(1'b0), .d(1'b0),
        .Q(q1), .nQ(nq1), .wrap(wrap1)
    );

    ttrigger #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
        .T(T), .rst_n(rst_n), .en(en4), .mode(mode4), .tog(tog4),
        .sclr(sclr4), .sset(sset4), .load(load4), .d(d4),
        .Q(q4), .nQ(nq4), .wrap(wrap4)
    );

    initial begin
        T = 1'b0;
        forever #5 T = ~T;
    end

    initial begin
        #200us;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_check++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h required=%h", tag, obs, expv);
    endtask

    task automatic set_in(input logic en, input logic mode, input logic [3:0] tog,
                          input logic clr, input logic set, input logic ld, input logic [3:0] d);
        en4 = en; mode4 = mode; tog4 = tog; sclr4 = clr; sset4 = set; load4 = ld; d4 = d;
    endtask

    // Model: counter mode is only driven with tog=4'hF, so it is a plain increment.
    task automatic step(input string tag);
        exp_t       e;
        logic [3:0] nq;
        logic       nw;
        if (sclr4)      nq = 4'h0;
        else if (sset4) nq = 4'hF;
        else if (load4) nq = d4;
        else if (!en4)  nq = exp4;
        else if (!mode4) nq = exp4 ^ tog4;
        else            nq = exp4 + 4'h1;
        nw = en4 && mode4 && !sclr4 && !sset4 && !load4 && (exp4 == 4'hF);
        exp4 = nq;
        exp1 = ~exp1;
        e.q = nq; e.w = nw; e.q1 = exp1; e.tag = tag;
        sb.push_back(e);
        @(posedge T);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".q4"},   q4,         e.q);
        chk({e.tag, ".nq4"},  nq4,        ~e.q);
        chk({e.tag, ".wrap"}, {3'b0, wrap4}, {3'b0, e.w});
        chk({e.tag, ".q1"},   {3'b0, q1},    {3'b0, e.q1});
        chk({e.tag, ".nq1"},  {3'b0, nq1},   {3'b0, ~e.q1});
        $display("step %-10s q4=%h wrap=%b q1=%b", e.tag, q4, wrap4, q1);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        exp4 = 4'h0;
        exp1 = 1'b0;
        repeat (2) @(posedge T);
        #1;
        chk("rst.q4",   q4,             4'h0);
        chk("rst.nq4",  nq4,            4'hF);
        chk("rst.wrap", {3'b0, wrap4},  4'h0);
        chk("rst.q1",   {3'b0, q1},     4'h0);
        chk("rst.nq1",  {3'b0, nq1},    4'h1);
        rst_n = 1'b1;

        // Classic TFF over 500 ns while the bank holds with en=0.
        for (int i = 0; i < 50; i++) step("tff");

        // Counter: 16 edges from 0 must come back to 0 with a single wrap.
        set_in(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 16; i++) step("count");
        step("count_post");

        // Per-bit toggle, then hold with en=0.
        set_in(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
        step("clr");
        set_in(1'b1, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step("toggle");
        en4 = 1'b0;
        for (int i = 0; i < 2; i++) step("hold");

        // Priority of synchronous controls, ungated by en.
        set_in(1'b1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 4'hA);
        step("prio_all");
        set_in(1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b1, 4'hA);
        step("prio_set");
        set_in(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 4'hA);
        step("prio_load");
        set_in(1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 4'hA);
        step("prio_en0");
        set_in(1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 4'h0);
        step("set_en0");

        // At all ones: sclr and load suppress wrap, plain counting wraps.
        set_in(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 4'h0);
        step("wrap_clr");
        set_in(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 4'hF);
        step("load_f");
        step("wrap_load");
        set_in(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0);
        step("wrap_cnt");
        step("wrap_end");

        // Reset between edges with the TFF at 1 and the bank non-zero.
        set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h6);
        step("pre_rst");
        if (exp1 != 1'b1) step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp4 = 4'h0;
        exp1 = 1'b0;
        chk("arst.q1",  {3'b0, q1},  4'h0);
        chk("arst.nq1", {3'b0, nq1}, 4'h1);
        chk("arst.q4",  q4,          4'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge T);
            #1;
            chk("arst_hold.q1", {3'b0, q1}, 4'h0);
            chk("arst_hold.q4", q4,         4'h0);
        end
        #2;
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) step("resume");

        if (sb.size() != 0) begin
            n_check++;
            $display("FAIL scoreboard observed=%0d required=0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
